mem_req_ctrl: RTL

- Request-side controller sitting directly upstream of the 4096x16 single-port RAM.
- Converts a valid/ready request stream (single writes, bursts of reads) into the RAM's addr/rw/bidirectional-data protocol.
- Returns read data on a valid/ready response stream.
- Sole owner of the RAM data bus; drives it only during write cycles.

---
 rtl/mem_req_ctrl_pkg.sv | 16 +
 rtl/mem_req_stats.sv | 29 ++
 rtl/mem_req_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared defaults and state encoding for mem_req_ctrl and its optional statistics block.
package mem_req_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_LEN_W  = 4;
  localparam int unsigned STAT_W     = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/mem_req_stats.sv
// Two saturating 16-bit event counters: write cycles and read-response handshakes.
module mem_req_stats
  import mem_req_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_inc_i,
  input  logic              rd_inc_i,
  output logic [STAT_W-1:0] wr_count_o,
  output logic [STAT_W-1:0] rd_count_o
);

  logic [STAT_W-1:0] wr_q;
  logic [STAT_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_inc_i && (wr_q != '1)) wr_q <= wr_q + STAT_W'(1);
      if (rd_inc_i && (rd_q != '1)) rd_q <= rd_q + STAT_W'(1);
    end
  end

  assign wr_count_o = wr_q;
  assign rd_count_o = rd_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller for a single-port RAM with a bidirectional data bus.
// Define MEM_REQ_CTRL_STATS_EN to add the wr_count/rd_count statistics outputs.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  inout  wire logic [DATA_W-1:0] mem_data
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] wr_count,
  output logic [STAT_W-1:0] rd_count
`endif
);

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rw_q,   mem_rw_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [LEN_W-1:0]  cnt_q,      cnt_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic              last_q,     last_d;

  // mem_addr_q doubles as the burst address; it only moves on entry to WRITE/READ.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rw_d   = mem_rw_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    last_d     = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mem_addr_d = req_addr;
          wdata_d    = req_wdata;
          len_d      = req_len;
          cnt_d      = '0;
          if (req_we) begin
            state_d  = ST_WRITE;
            mem_rw_d = 1'b1;
          end else begin
            state_d  = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        state_d  = ST_IDLE;
        mem_rw_d = 1'b0;
      end
      ST_READ: begin
        rdata_d = mem_data;
        last_d  = (cnt_q == len_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            cnt_d      = cnt_q + LEN_W'(1);
            state_d    = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_rw_q   <= 1'b0;
      wdata_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rw_q   <= mem_rw_d;
      wdata_q    <= wdata_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      last_q     <= last_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_last  = last_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rw    = mem_rw_q;
  assign mem_data  = mem_rw_q ? wdata_q : {DATA_W{1'bz}};

`ifdef MEM_REQ_CTRL_STATS_EN
  mem_req_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .wr_inc_i   (state_q == ST_WRITE),
    .rd_inc_i   ((state_q == ST_RESP) && rsp_ready),
    .wr_count_o (wr_count),
    .rd_count_o (rd_count)
  );
`endif

endmodule
